store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-path counterpart to the load-path sign extension in the MIPS datapath.
- Takes a 32-bit register value, byte address and access size (SB/SH/SW) from the MEM stage.
- Narrows and replicates the value into the correct little-endian byte lanes, generates byte strobes and checks alignment.
- Issues a single write to data memory over a valid/ready handshake, and pulses completion or misalignment status back to the pipeline.

Parameters:
- WORD_SIZE, 32, datapath width in bits; only 32 supported (4 byte lanes).
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline presents a store request.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_W  byte address of the store.
- req_data  input  WORD_SIZE  source register value; low byte/half used for SB/SH.
- req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
- mem_wvalid  output  1  write request to data memory.
- mem_wready  input  1  data memory accepts the write.
- mem_waddr  output  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_wdata  output  WORD_SIZE  lane-positioned write data.
- mem_wstrb  output  4  byte enables; bit i covers wdata[8i+7:8i].
- done  output  1  one-cycle pulse: store completed.
- misalign  output  1  one-cycle pulse: request rejected, no write issued.
- busy  output  1  high when not in IDLE.

Behaviour:
- Reset (async assert, sync release to IDLE) drives:
  - mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wstrb=0.
  - done=0, misalign=0, busy=0, req_ready=1.
- States:
  - IDLE: req_ready=1, busy=0.
  - ISSUE: mem_wvalid=1, req_ready=0, busy=1.
  - ERR: req_ready=0, busy=1, single cycle.
- Acceptance: req_valid && req_ready at rising edge N.
- Alignment check, evaluated in IDLE:
  - Half: misaligned if addr[0]=1.
  - Word: misaligned if addr[1:0]!=0.
  - req_size=11: always treated as misaligned.
- Misaligned request:
  - Go to ERR. misalign=1 during cycle N+1; memory is never touched.
  - Return to IDLE at N+2.
- Aligned request: all outputs registered.
  - Enter ISSUE with mem_wvalid=1 in cycle N+1 (latency 1).
- Lane mapping (little-endian, k=addr[1:0]):
  - Byte: wdata={4{data[7:0]}}, wstrb=4'b0001<<k.
  - Half: wdata={2{data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - Word: wdata=data, wstrb=4'b1111.
  - waddr = {addr[ADDR_W-1:2],2'b00}.
- ISSUE hold: waddr/wdata/wstrb/wvalid held stable until mem_wready=1 at an edge; request inputs ignored meanwhile.
- On the mem_wready edge: go to IDLE, mem_wvalid=0 next cycle, done=1 for that one cycle.
  - Earliest next acceptance is the same cycle done is high (req_ready=1 in IDLE).
- mem_wready while mem_wvalid=0 is ignored.
- Reset mid-ISSUE: write abandoned, mem_wvalid drops asynchronously, no done pulse.
- done and misalign are never high simultaneously.

Optional Feature:
- Macro: STORE_ZERO_LANES_EN.
- Defined: byte lanes whose wstrb bit is 0 are driven to 8'h00 in mem_wdata (eases waveform debug and memory models that ignore strobes).
- Undefined: inactive lanes carry the replicated value as specified above.
- Strobes, timing and state machine are identical in both builds.

Test Plan:
- SB, addr 0x0000_1003, data 0xDEADBEEF -> cycle N+1: waddr 0x0000_1000, wdata 0xEFEFEFEF (0xEF000000 with STORE_ZERO_LANES_EN), wstrb 4'b1000; with mem_wready=1, done pulses at N+2.
- SH, addr 0x0000_2002, data 0x12345678 -> wdata 0x56785678, wstrb 4'b1100. SW, addr 0x0000_2004, data 0xCAFEF00D -> wdata 0xCAFEF00D, wstrb 4'b1111.
- SW, addr 0x0000_3001; SH, addr 0x0000_3003; size 11 -> each gives misalign pulse at N+1, mem_wvalid never asserts, req_ready low one cycle then high.
- SB, addr 0x10, mem_wready held low 3 cycles -> wvalid/waddr/wdata/wstrb stable for 4 cycles, req_ready=0 throughout; done one cycle after the wready edge.
- Assert rst_n=0 mid-ISSUE -> mem_wvalid, busy, done 0 immediately. After release, a new SW to 0x40 completes normally.
- Back-to-back: req_valid held high with stores to 0x0, 0x4, 0x8, mem_wready=1 -> three writes, one accepted every 2 cycles, three done pulses in order.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: MIPS store path; places data in byte lanes, builds strobes, checks alignment.
// Build option STORE_ZERO_LANES_EN zeroes inactive byte lanes in mem_wdata.
module store_unit #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_data,
    input  logic [1:0]           req_size,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    output logic                 done,
    output logic                 misalign,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 bad;
    logic [3:0]           strb_c;
    logic [WORD_SIZE-1:0] rep_c;
    logic [WORD_SIZE-1:0] wdata_c;
    logic                 done_q;

    assign accept = req_valid && req_ready;
    assign done   = done_q;

    // Size decode: replicate the narrow value, pick lanes, flag misalignment
    always_comb begin
        bad    = 1'b0;
        strb_c = 4'b0000;
        rep_c  = '0;
        unique case (1'b1)
            req_size == 2'b00: begin
                strb_c = 4'b0001 << req_addr[1:0];
                rep_c  = {4{req_data[7:0]}};
            end
            req_size == 2'b01: begin
                bad    = req_addr[0];
                strb_c = req_addr[1] ? 4'b1100 : 4'b0011;
                rep_c  = {2{req_data[15:0]}};
            end
            req_size == 2'b10: begin
                bad    = |req_addr[1:0];
                strb_c = 4'b1111;
                rep_c  = req_data;
            end
            default: bad = 1'b1;
        endcase
    end

`ifdef STORE_ZERO_LANES_EN
    logic [WORD_SIZE-1:0] lane_mask;

    assign lane_mask = {{8{strb_c[3]}}, {8{strb_c[2]}},
                        {8{strb_c[1]}}, {8{strb_c[0]}}};
    assign wdata_c   = rep_c & lane_mask;
`else
    assign wdata_c   = rep_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = bad ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_wready) begin
                    state_nx = IDLE;
                end
            end
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_wvalid = 1'b0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ISSUE:   mem_wvalid = 1'b1;
            ERR:     misalign   = 1'b1;
            default: busy       = 1'b1;
        endcase
    end

    // Write beat is captured once and held for the whole ISSUE stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == ISSUE) && mem_wready;
            if (accept && !bad) begin
                mem_waddr <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata_c;
                mem_wstrb <= strb_c;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized and directed checks of store_unit against a lane model.
// Honours STORE_ZERO_LANES_EN the same way as the design build.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        misalign;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_unit #(.WORD_SIZE(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .done       (done),
        .misalign   (misalign),
        .busy       (busy)
    );

    // Reference: access of n = 2^size bytes at offset addr%4, value bytes repeated per lane
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s, output logic bad,
                                  output logic [3:0] strb, output logic [31:0] wd);
        int n;
        int off;
        logic act;
        n    = 1 << s;
        off  = int'(a % 4);
        bad  = (s == 2'b11) || ((a % n) != 0);
        strb = 4'b0000;
        wd   = '0;
        for (int i = 0; i < 4; i++) begin
            act     = (i >= off) && (i < off + n);
            strb[i] = act;
`ifdef STORE_ZERO_LANES_EN
            wd[8*i +: 8] = act ? d[8*(i % n) +: 8] : 8'h00;
`else
            wd[8*i +: 8] = d[8*(i % n) +: 8];
`endif
        end
    endfunction

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] got;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_size   = '0;
        mem_wready = 1'b0;
        #2;
        got = {mem_wvalid, |mem_waddr, |mem_wdata, |mem_wstrb,
               done, misalign, busy, req_ready, 1'b0};
        checks++;
        if (got !== 9'b000000010) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000010", got);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, busy, mem_wvalid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got %b want 100",
                     {req_ready, busy, mem_wvalid});
        end
    endtask

    task automatic test_lane_mapping;
        logic [31:0] ta[7] = '{32'h0000_1003, 32'h0000_2002, 32'h0000_2004,
                               32'h0000_3001, 32'h0000_3003, 32'h0000_3000,
                               32'h0000_0010};
        logic [31:0] td[7] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D,
                               32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                               32'hA5C3_7E19};
        logic [1:0]  ts[7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
        int          tw[7] = '{0, 0, 0, 0, 0, 0, 3};
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        int          w;
        logic        bad;
        logic [3:0]  es;
        logic [31:0] ew;
        logic [72:0] got;
        logic [72:0] exp;
        for (int k = 0; k < 31; k++) begin
            if (k < 7) begin
                a = ta[k]; d = td[k]; s = ts[k]; w = tw[k];
            end else begin
                a = $urandom; d = $urandom;
                s = 2'($urandom_range(0, 3));
                w = $urandom_range(0, 3);
            end
            model(a, d, s, bad, es, ew);
            drive_req(a, d, s);
            if (bad) begin
                checks++;
                if ({mem_wvalid, misalign, req_ready, busy, done} !== 5'b01010) begin
                    errors++;
                    $display("FAIL misalign_pulse a=%h s=%0d got %b want 01010", a, s,
                             {mem_wvalid, misalign, req_ready, busy, done});
                end
                @(posedge clk);
                #1;
                checks++;
                if ({mem_wvalid, misalign, req_ready, busy, done} !== 5'b00100) begin
                    errors++;
                    $display("FAIL misalign_end a=%h got %b want 00100", a,
                             {mem_wvalid, misalign, req_ready, busy, done});
                end
                continue;
            end
            exp = {1'b1, a & 32'hFFFF_FFFC, ew, es, 4'b0100};
            for (int c = 0; c <= w; c++) begin
                got = {mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
                       req_ready, busy, done, misalign};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL issue a=%h s=%0d cyc=%0d got %h want %h",
                             a, s, c, got, exp);
                end
                @(negedge clk);
                mem_wready = (c == w);
                @(posedge clk);
                #1;
            end
            checks++;
            if ({mem_wvalid, done, misalign, req_ready, busy} !== 5'b01010) begin
                errors++;
                $display("FAIL done_pulse a=%h got %b want 01010", a,
                         {mem_wvalid, done, misalign, req_ready, busy});
            end
            @(negedge clk);
            mem_wready = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width a=%h got %b want 0", a, done);
            end
        end
    endtask

    task automatic test_reset_mid_issue;
        logic bad;
        logic [3:0]  es;
        logic [31:0] ew;
        drive_req(32'h0000_0010, 32'h0000_00AB, 2'b00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_wvalid, busy, done, misalign, req_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_mid_issue got %b want 00001",
                     {mem_wvalid, busy, done, misalign, req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(32'h40, 32'h0BAD_F00D, 2'b10, bad, es, ew);
        drive_req(32'h40, 32'h0BAD_F00D, 2'b10);
        checks++;
        if ({mem_wvalid, mem_waddr, mem_wdata, mem_wstrb} !== {1'b1, 32'h40, ew, es}) begin
            errors++;
            $display("FAIL post_reset_sw got %b %h %h %b want 1 00000040 %h %b",
                     mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, ew, es);
        end
        @(negedge clk);
        mem_wready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, mem_wvalid} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_done got %b want 10", {done, mem_wvalid});
        end
        @(negedge clk);
        mem_wready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int wr = 0;
        int dn = 0;
        int wcyc[$];
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        req_valid  = 1'b1;
        req_size   = 2'b10;
        req_data   = d;
        req_addr   = 32'h0;
        mem_wready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                checks++;
                if (dn + 1 != wr) begin
                    errors++;
                    $display("FAIL b2b_done_order got done#%0d after %0d writes", dn, wr);
                end
                dn++;
            end
            if (mem_wvalid) begin
                checks++;
                if ({mem_waddr, mem_wdata, mem_wstrb} !== {32'(wr * 4), d, 4'b1111}) begin
                    errors++;
                    $display("FAIL b2b_write%0d got %h %h %b want %h %h 1111", wr,
                             mem_waddr, mem_wdata, mem_wstrb, 32'(wr * 4), d);
                end
                wcyc.push_back(cyc);
                wr++;
                if (wr < 3) req_addr = 32'(wr * 4);
                else req_valid = 1'b0;
            end
        end
        mem_wready = 1'b0;
        checks++;
        if (wr != 3 || dn != 3) begin
            errors++;
            $display("FAIL b2b_count got writes=%0d dones=%0d want 3 3", wr, dn);
        end else begin
            checks++;
            if (wcyc[1] - wcyc[0] != 2 || wcyc[2] - wcyc[1] != 2) begin
                errors++;
                $display("FAIL b2b_spacing got %0d %0d %0d want 2-cycle steps",
                         wcyc[0], wcyc[1], wcyc[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lane_mapping();
        test_reset_mid_issue();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
